// File: rtl/core_mdu.sv
// rtl/core_mdu.sv - RV32M iterative multiply/divide unit with valid-ready handshake
module core_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      mdusel,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      sel_q;
  logic            sign1;
  logic            sign2;
  // acc: product high half / partial remainder
  // lo : multiplier, shifting out / dividend shifting into quotient
  // opb: multiplicand magnitude / divisor magnitude
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opb;

  logic            accept;
  logic            is_div;
  logic            s1_use;
  logic            s2_use;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] fast_res;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ge;
  logic [XLEN-1:0] acc_step;
  logic [XLEN-1:0] lo_step;

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fix_res;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign accept     = req_ready && req_valid && !flush;

  // Operand decode: which operands are viewed as signed, and their magnitudes
  assign is_div = mdusel[2];
  assign s1_use = (mdusel == 3'b001) || (mdusel == 3'b010) ||
                  (mdusel == 3'b100) || (mdusel == 3'b110);
  assign s2_use = (mdusel == 3'b001) || (mdusel == 3'b100) || (mdusel == 3'b110);
  assign neg1   = s1_use && op1[XLEN-1];
  assign neg2   = s2_use && op2[XLEN-1];
  assign mag1   = neg1 ? (~op1 + 1'b1) : op1;
  assign mag2   = neg2 ? (~op2 + 1'b1) : op2;

  // Fast path: division by zero and the single signed-overflow case
  assign div_zero = is_div && (op2 == '0);
  assign div_ovf  = ((mdusel == 3'b100) || (mdusel == 3'b110)) &&
                    (op1 == MIN_NEG) && (op2 == '1);
  assign fast_res = div_zero ? (mdusel[1] ? op1 : '1)
                             : (mdusel[1] ? '0 : op1);

  // Multiply step: conditional add into the high half, then shift the pair right
  assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);

  // Divide step: shift {rem, dividend} left and trial-subtract the divisor;
  // a set top bit of the shifted remainder already means it exceeds the divisor
  assign div_shift = {acc, lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_ge    = div_shift[XLEN] || !div_diff[XLEN];

  assign acc_step = sel_q[2] ? (div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0])
                             : mul_sum[XLEN:1];
  assign lo_step  = sel_q[2] ? {lo[XLEN-2:0], div_ge}
                             : {mul_sum[0], lo[XLEN-1:1]};

  // Sign correction and result selection
  assign prod    = {acc, lo};
  assign prod_s  = (sign1 ^ sign2) ? (~prod + 1'b1) : prod;
  assign quo_s   = (sign1 ^ sign2) ? (~lo + 1'b1) : lo;
  assign rem_s   = sign1 ? (~acc + 1'b1) : acc;
  assign fix_res = sel_q[2] ? (sel_q[1] ? rem_s : quo_s)
                            : ((sel_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                                     : prod_s[2*XLEN-1:XLEN]);

  // Control FSM and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (div_zero || div_ovf) begin
              state <= S_DONE;
            end else begin
              state <= S_CALC;
              cnt   <= CW'(XLEN - 1);
            end
          end
        end
        S_CALC: begin
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIX: state <= S_DONE;
        S_DONE: begin
          if (resp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shared datapath registers and the registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      opb    <= '0;
      result <= '0;
    end else if (!flush) begin
      if (accept) begin
        sel_q <= mdusel;
        sign1 <= neg1;
        sign2 <= neg2;
        acc   <= '0;
        lo    <= is_div ? mag1 : mag2;
        opb   <= is_div ? mag2 : mag1;
        if (div_zero || div_ovf) begin
          result <= fast_res;
        end
      end else if (state == S_CALC) begin
        acc <= acc_step;
        lo  <= lo_step;
      end else if (state == S_FIX) begin
        result <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_core_mdu.sv
// tb/tb_core_mdu.sv - directed self-checking bench for core_mdu
module tb_core_mdu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            resp_ready = 1'b0;
  logic [2:0]      mdusel = 3'b000;
  logic [XLEN-1:0] op1 = '0;
  logic [XLEN-1:0] op2 = '0;
  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] result;

  int total = 0;
  int bad = 0;

  core_mdu #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mdusel     (mdusel),
    .op1        (op1),
    .op2        (op2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; returns positioned in cycle 1 after accept
  task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    mdusel    = sel;
    op1       = a;
    op2       = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Count cycles from accept until resp_valid (bounded)
  task automatic wait_resp(output int n);
    n = 1;
    while (!resp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("req_ready after ack", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [2:0] sel, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    issue(sel, a, b);
    wait_resp(n);
    chk({tag, " result"}, result, exp);
    chk({tag, " latency"}, n, lat);
    ack();
  endtask

  initial begin
    int n;
    int seen;

    // Reset values
    #1;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply
    run("MULH min*min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run("MUL -1*-1", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34);
    run("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run("MUL 1234*5678", 3'b000, 32'd1234, 32'd5678, 32'd7006652, 34);

    // Divide
    run("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    run("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    run("DIVU big", 3'b101, 32'hFFFFFFFF, 32'h80000000, 32'd1, 34);

    // Fast paths
    run("DIVU /0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run("REMU /0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    run("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Back-pressure: hold the response for 10 cycles
    issue(3'b101, 32'd100, 32'd7);
    wait_resp(n);
    chk("bp latency", n, 34);
    for (int i = 0; i < 10; i++) begin
      chk("bp result", result, 32'd14);
      chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    ack();

    // Asynchronous reset mid-CALC
    issue(3'b000, 32'd3, 32'd5);
    repeat (5) begin @(posedge clk); #1; end
    chk("pre-reset busy", {31'd0, req_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("async reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("async reset result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1;
    end
    chk("no resp after reset", seen, 0);

    // Flush at CALC cycle 5 with a simultaneous request
    issue(3'b101, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    chk("pre-flush busy", {31'd0, req_ready}, 32'd0);
    flush     = 1'b1;
    req_valid = 1'b1;
    mdusel    = 3'b000;
    op1       = 32'd3;
    op2       = 32'd4;
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush idle", {31'd0, req_ready}, 32'd1);
    chk("flush resp_valid", {31'd0, resp_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid || !req_ready) seen = 1;
    end
    chk("flush no activity", seen, 0);
    run("MUL after flush", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_mdu.md
# core_mdu

Parametrised multi-cycle multiply/divide unit implementing the RV32M operation set beside the single-cycle integer ALU in the execute stage. It runs a radix-2 iterative shift-add multiplier and a restoring divider over a shared datapath. A request/response valid-ready handshake stalls the pipeline while an operation is in flight. Divide-by-zero and signed overflow finish on a one-cycle fast path, and a flush input aborts any operation.

## Interface
- XLEN, 32, operand/result width; even, ≥ 4
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  abort current operation, return to IDLE
- req_valid  input  1  request present
- req_ready  output  1  unit can accept request (high only in IDLE)
- mdusel  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1  input  XLEN  rs1 operand (multiplicand / dividend)
- op2  input  XLEN  rs2 operand (multiplier / divisor)
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes result
- result  output  XLEN  operation result, stable while resp_valid

## Operation
- States: IDLE, CALC, FIX, DONE. A 2-bit state register plus a $clog2(XLEN)-bit iteration counter.
- Accept: req_valid && req_ready in IDLE. On acceptance the unit latches the opcode and operand signs.
  - The signed view of an operand is used for: op1 in MULH/MULHSU/DIV/REM, and op2 in MULH/DIV/REM.
  - It latches operand magnitudes (two's-complement negate if the signed view is negative).
- Fast path, decided in IDLE at acceptance:
  - Divide by zero: op2 == 0 for ops 1xx. DIV/DIVU give all-ones; REM/REMU give op1. Next state DONE.
  - Signed overflow: op1 == 1<<(XLEN-1) and op2 == all-ones, for DIV/REM only. DIV gives op1 and REM gives 0. Next state DONE.
- All other accepts go to CALC with counter = XLEN-1.
- CALC (multiply), one iteration per cycle:
  - If the multiplier LSB is set, add the multiplicand magnitude to the upper half of the 2·XLEN product register.
  - Then shift right one bit.
- CALC (divide), restoring, one quotient bit per cycle:
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor using an XLEN+1-bit subtractor.
  - If non-negative, keep the difference and set quotient bit 1; otherwise set 0.
- CALC exits to FIX when counter == 0; otherwise the counter decrements.
- FIX performs sign correction and result selection, registering into result:
  - Product negated when sign1 ^ sign2.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Quotient negated when sign1 ^ sign2; remainder negated when sign1 (takes the sign of the dividend).
- DONE: resp_valid = 1. Holds result until resp_ready, then goes to IDLE on the next edge.
- Reset values: state IDLE, req_ready 1, resp_valid 0, result 0, counter 0, datapath registers 0.
- Flush:
  - In any state, the next state is IDLE and resp_valid drops on the next edge.
  - A request presented in the same cycle as flush is NOT accepted.
  - result is not cleared.
- Reset asserted mid-operation immediately forces IDLE and the reset values above, with no response produced.
- All arithmetic is modulo 2^XLEN (or 2^(2·XLEN) for the product); no exceptions or flags.

## Timing
- req_ready is combinational from state only (IDLE), never from req_valid.
- Normal op: acceptance edge E; CALC for XLEN cycles; FIX for 1 cycle; resp_valid high from edge E+XLEN+2.
  - Latency is XLEN+2 cycles (34 at XLEN=32).
- Fast path: resp_valid high from edge E+1.
- Throughput: no overlap. The next request can be accepted at the earliest one cycle after the response handshake.
- resp_valid, result and state are registered outputs, with no combinational path from inputs to them.

## Test plan
- Reset with rst_n low asynchronously mid-CALC (XLEN=32) -> outputs immediately show req_ready=1 and resp_valid=0, with no later response.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MUL 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000001; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. Each sets resp_valid exactly 34 cycles after accept.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each 1 cycle after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, each 1 cycle after accept.
- Back-pressure: hold resp_ready=0 for 10 cycles after resp_valid -> result and resp_valid stable and req_ready=0 throughout; then a resp_ready pulse -> req_ready=1 on the next cycle.
- Flush at CALC cycle 5 with req_valid simultaneously high -> IDLE next cycle, no response, request not taken; a request after that completes correctly.
